seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Consumes the 24-bit packed BCD time word (hh:mm:ss) from the time counter and drives a
//  6-digit multiplexed, common-anode 7-segment display. Time-multiplexes one digit per scan
//  slot and decodes BCD to active-low segments. Takes a frame-coherent snapshot so a digit
//  never shows a half-updated time. Sits between the time counter and the board display pins.
// PARAMETERS
//  SCAN_DIV   100000    CLK cycles per digit slot (>=2); 1 kHz digit rate at 100 MHz
//  BLINK_DIV  50000000  CLK cycles per separator-blink half period (used only with BLINK_COLON_EN)
// PORTS
//  CLK     in   1   system clock, all state on rising edge
//  reset   in   1   asynchronous, active-high reset
//  data    in   24  packed BCD: [23:20] hr tens,[19:16] hr units,[15:12] min tens,[11:8] min units,
//                   [7:4] sec tens,[3:0] sec units
//  an      out  6   digit enables, active-low one-hot; an[i] drives digit i (0 = rightmost)
//  seg     out  7   segments active-low, seg[6:0] = {a,b,c,d,e,f,g}
//  dp      out  1   decimal point, active-low
// BEHAVIOUR
//  - Reset (async assert): scan_cnt=0, digit=0, snap=24'h000000, an=6'h3F, seg=7'h7F, dp=1,
//    blink phase=1. Outputs stay blank while reset is high; reset mid-scan aborts the frame.
//  - Prescaler: scan_cnt counts 0..SCAN_DIV-1 and wraps; tick = (scan_cnt==SCAN_DIV-1).
//  - Digit index 0..5: advances on tick, 5 wraps to 0. Never holds a value >5.
//  - Snapshot: snap <= data on the tick where digit goes 5->0 (frame start). Only snap is decoded;
//    data changes mid-frame are invisible until the next frame. First frame after reset shows 000000.
//  - Outputs registered, 1-cycle latency from digit/snap: an = ~(6'b1<<digit); seg = decode(nibble
//    digit of snap); first cycle after reset release shows digit 0. Exactly one an bit low at a time.
//  - Decode: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000
//    7=0001111 8=0000000 9=0000100; nibbles A-F -> dash 1111110 (g only).
//  - Separators: dp low on digits 2 and 4 (hr units, min units), high elsewhere.
//  - All counters free-running; no enable/handshake; display repeats every 6*SCAN_DIV cycles.
// CONFIGURATION
//  BLINK_COLON_EN defined: blink counter counts 0..BLINK_DIV-1, toggles phase on wrap; dp on
//    digits 2/4 is low only when phase=1, else high (separators flash at CLK/(2*BLINK_DIV)).
//  BLINK_COLON_EN undefined: no blink counter/phase logic; dp on digits 2/4 steady low.
//    BLINK_DIV ignored. Digit/segment behaviour identical in both builds.
// TESTING (bench uses SCAN_DIV=4, BLINK_DIV=8)
//  1 Reset high, data=24'h235945 -> an=111111, seg=1111111, dp=1 throughout reset.
//  2 Release reset, data=24'h235945 -> first frame an 111110..011111 all seg=0000001; after
//    first 5->0 wrap: an=111110 seg=0100100 (5), next slot an=111101 seg=1001100 (4), ...,
//    an=011111 seg=0010010 (2); dp=0 only while an=111011 or 101111.
//  3 Change data 24'h235945->24'h000000 while digit=2 -> digits 3..5 still show 2,3,5 (hr 23, min 5)
//    until frame end; next frame shows all 0000001.
//  4 data=24'hAB0000 -> an=011111 and an=101111 both seg=1111110 (dash).
//  5 Assert reset for 1 cycle mid-slot at digit=3 -> outputs blank immediately, restart at
//    an=111110 with seg=0000001 after release.
//  6 BLINK_COLON_EN build -> dp on digits 2/4 low for 8 cycles then high for 8 cycles, repeating;
//    non-blink build -> dp low on every digit-2/4 slot.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Six-digit multiplexed common-anode 7-segment driver for a packed BCD hh:mm:ss word, with a per-frame snapshot.
// Latency: outputs are registered one cycle behind the digit/snapshot state. Backpressure: none, free-running scan.
// BLINK_COLON_EN (optional define): separator decimal points flash at CLK/(2*BLINK_DIV) instead of staying lit.
module seg7_scan_display #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [23:0] data,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_param_check
    $error("seg7_scan_display: SCAN_DIV must be >= 2 and BLINK_DIV >= 1");
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit;
  logic [23:0]       snap;
  logic              tick;
  logic              frame_end;

  logic [5:0]        an_nxt;
  logic [3:0]        nibble;
  logic              sep_slot;
  logic              sep_on;

  assign tick      = (scan_cnt == SCAN_LAST);
  assign frame_end = tick && (digit == 3'd5);

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
    end else if (tick) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      digit <= 3'd0;
    end else if (tick) begin
      digit <= (digit >= 3'd5) ? 3'd0 : digit + 3'd1;
    end
  end

  // Latch the time only at frame start so all six digits come from one coherent sample.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      snap <= 24'h000000;
    end else if (frame_end) begin
      snap <= data;
    end
  end

`ifdef BLINK_COLON_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  assign sep_on = blink_phase;
`else
  assign sep_on = 1'b1;
`endif

  always_comb begin
    an_nxt   = 6'h3F;
    nibble   = 4'h0;
    sep_slot = 1'b0;
    case (digit)
      3'd0: begin an_nxt = 6'b111110; nibble = snap[3:0];   end
      3'd1: begin an_nxt = 6'b111101; nibble = snap[7:4];   end
      3'd2: begin an_nxt = 6'b111011; nibble = snap[11:8];  sep_slot = 1'b1; end
      3'd3: begin an_nxt = 6'b110111; nibble = snap[15:12]; end
      3'd4: begin an_nxt = 6'b101111; nibble = snap[19:16]; sep_slot = 1'b1; end
      3'd5: begin an_nxt = 6'b011111; nibble = snap[23:20]; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      an  <= 6'h3F;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= decode(nibble);
      dp  <= ~(sep_slot & sep_on);
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: directed + random data against an arithmetic reference model.
module tb_seg7_scan_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;
  localparam int FRAME     = 6 * SCAN_DIV;

  logic        CLK;
  logic        reset;
  logic [23:0] data;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int total = 0;
  int bad   = 0;

  seg7_scan_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .CLK  (CLK),
    .reset(reset),
    .data (data),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [6:0] dec_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110
  };

  // Reference model: k = clock edges since reset release; everything derived arithmetically from k.
  int          k;
  logic [23:0] m_snap;
  logic [5:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      k       = 0;
      m_snap  = 24'h000000;
      exp_an  = 6'h3F;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      int   d;
      logic phase;
      logic [5:0] one;
      logic [23:0] sh;
      one     = 6'b000001;
      d       = (k / SCAN_DIV) % 6;
      exp_an  = ~(one << d);
      sh      = m_snap >> (4 * d);
      exp_seg = dec_tbl[sh[3:0]];
`ifdef BLINK_COLON_EN
      phase   = ((k / BLINK_DIV) % 2) == 0;
`else
      phase   = 1'b1;
`endif
      exp_dp  = !((d == 2 || d == 4) && phase);
      k       = k + 1;
      if (k % FRAME == 0) m_snap = data;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (k=%0d)", tag, obs, exp_v, k);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_an"},  {2'b00, an},  {2'b00, exp_an});
    chk({tag, "_seg"}, {1'b0, seg},  {1'b0, exp_seg});
    chk({tag, "_dp"},  {7'b0, dp},   {7'b0, exp_dp});
    if (!reset) chk({tag, "_onehot"}, 8'($countones(~an)), 8'd1);
  endtask

  task automatic step(input string tag);
    @(negedge CLK);
    check_outputs(tag);
  endtask

  function automatic logic [23:0] rand_bcd();
    logic [23:0] w;
    w = 24'h0;
    for (int i = 0; i < 6; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
    return w;
  endfunction

  initial begin
    reset = 1'b1;
    data  = 24'h235945;

    // Blank throughout reset.
    repeat (3) begin
      step("rst");
      chk("rst_an_const",  {2'b00, an}, 8'h3F);
      chk("rst_seg_const", {1'b0, seg}, 8'h7F);
    end

    // Release; first frame shows zeros, then the snapshot of 235945.
    reset = 1'b0;
    step("first");
    chk("first_an_const",  {2'b00, an}, 8'b00111110);
    chk("first_seg_const", {1'b0, seg}, 8'b00000001);
    repeat (2 * FRAME + 4) step("frame");

    // Change data while digit 2 is selected: the current frame must keep the old snapshot.
    for (int i = 0; i < FRAME && ((k / SCAN_DIV) % 6) != 2; i++) step("seek2");
    data = 24'h000000;
    repeat (2 * FRAME) step("midframe");

    // Non-decimal nibbles decode to a dash.
    data = 24'hAB0000;
    repeat (2 * FRAME + 2) step("dash");

    // One-cycle reset mid-slot at digit 3.
    for (int i = 0; i < 2 * FRAME && !(((k / SCAN_DIV) % 6) == 3 && (k % SCAN_DIV) == 1); i++)
      step("seek3");
    reset = 1'b1;
    #1;
    chk("async_an",  {2'b00, an}, 8'h3F);
    chk("async_seg", {1'b0, seg}, 8'h7F);
    chk("async_dp",  {7'b0, dp},  8'h01);
    step("midrst");
    reset = 1'b0;
    step("restart");
    chk("restart_an_const",  {2'b00, an}, 8'b00111110);
    chk("restart_seg_const", {1'b0, seg}, 8'b00000001);
    repeat (FRAME) step("restart_run");

    // Random data, changed at random points of the scan.
    repeat (30) begin
      data = ($urandom_range(0, 3) == 0) ? 24'($urandom) : rand_bcd();
      repeat ($urandom_range(1, 30)) step("rand");
    end

    // Long steady run covering several blink periods.
    data = 24'h125907;
    repeat (4 * FRAME) step("steady");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
